// File: rtl/stp_phase_drv_if.sv
// stp_phase_drv_if: step/direction inputs and coil-drive outputs of the phase sequencer
//   en        : driver enable (0 forces coils off)
//   dir       : step direction, 1 = CW, 0 = CCW
//   pulse     : step request, each 0->1 transition is one step
//   coil      : coil drive {A,B,C,D}, 1 = energized
//   pos_o     : step count modulo 256
//   energized : 1 while coil drives a phase pattern
// master drives the step inputs; slave is the sequencer.
interface stp_phase_drv_if;
    logic       en;
    logic       dir;
    logic       pulse;
    logic [3:0] coil;
    logic [7:0] pos_o;
    logic       energized;
    modport master (output en, dir, pulse, input coil, pos_o, energized);
    modport slave  (input en, dir, pulse, output coil, pos_o, energized);
endinterface

// File: rtl/stp_phase_drv.sv
// stp_phase_drv: stepper coil phase sequencer with wrap-around step count and idle de-energize
//   clk_i     : system clock (1 kHz nominal)
//   rst_i     : asynchronous active-high reset
//   bus       : stp_phase_drv_if.slave (en, dir, pulse in; coil, pos_o, energized out)
//   IDLE_TO   : idle clocks without a step before the coils relax, 0 disables (0..65535)
// Build option: define STP_HALF_STEP_EN for the 8-entry half-step table; otherwise
// the 4-entry full-step two-phase-on table is used.
module stp_phase_drv #(
    parameter int IDLE_TO = 1000
) (
    input logic           clk_i,
    input logic           rst_i,
    stp_phase_drv_if.slave bus
);
`ifdef STP_HALF_STEP_EN
    localparam int IW = 3;
`else
    localparam int IW = 2;
`endif
    localparam logic [IW-1:0] IDX_ONE = IW'(1);

    typedef enum logic [1:0] {S_OFF, S_HOLD, S_RELAX} state_t;

    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_idx, w_idx_nxt, w_idx_step;
    logic [7:0]    r_pos, w_pos_nxt, w_pos_step;
    logic [15:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [3:0]    r_coil, w_coil_nxt;
    logic          r_energized, w_energized_nxt;
    logic          r_pulse_q;
    logic          w_rise, w_timeout;

    function automatic logic [3:0] phase(input logic [IW-1:0] i);
`ifdef STP_HALF_STEP_EN
        case (i)
            3'd0:    phase = 4'b1000;
            3'd1:    phase = 4'b1100;
            3'd2:    phase = 4'b0100;
            3'd3:    phase = 4'b0110;
            3'd4:    phase = 4'b0010;
            3'd5:    phase = 4'b0011;
            3'd6:    phase = 4'b0001;
            default: phase = 4'b1001;
        endcase
`else
        case (i)
            2'd0:    phase = 4'b1100;
            2'd1:    phase = 4'b0110;
            2'd2:    phase = 4'b0011;
            default: phase = 4'b1001;
        endcase
`endif
    endfunction

    assign w_rise     = bus.pulse & ~r_pulse_q;
    assign w_idx_step = bus.dir ? r_idx + IDX_ONE : r_idx - IDX_ONE;
    assign w_pos_step = bus.dir ? r_pos + 8'd1 : r_pos - 8'd1;
    assign w_cnt_inc  = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    // Fires on the edge where the counter would reach IDLE_TO; never true for IDLE_TO=0.
    assign w_timeout  = ({1'b0, r_cnt} + 17'd1) == 17'(IDLE_TO);

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_pos_nxt       = r_pos;
        w_cnt_nxt       = r_cnt;
        w_coil_nxt      = 4'b0000;
        w_energized_nxt = 1'b0;
        case (r_state)
            S_OFF: begin
                if (bus.en) begin
                    w_state_nxt     = S_HOLD;
                    w_cnt_nxt       = 16'd0;
                    w_coil_nxt      = phase(r_idx);
                    w_energized_nxt = 1'b1;
                end
            end
            S_HOLD, S_RELAX: begin
                if (!bus.en) begin
                    w_state_nxt = S_OFF;
                end else if (w_rise) begin
                    // A step beats a coincident timeout and wakes RELAX.
                    w_state_nxt     = S_HOLD;
                    w_idx_nxt       = w_idx_step;
                    w_pos_nxt       = w_pos_step;
                    w_cnt_nxt       = 16'd0;
                    w_coil_nxt      = phase(w_idx_step);
                    w_energized_nxt = 1'b1;
                end else if (r_state == S_HOLD) begin
                    w_cnt_nxt       = w_cnt_inc;
                    w_state_nxt     = w_timeout ? S_RELAX : S_HOLD;
                    w_coil_nxt      = w_timeout ? 4'b0000 : phase(r_idx);
                    w_energized_nxt = ~w_timeout;
                end
            end
            default: w_state_nxt = S_OFF;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_OFF;
            r_idx       <= '0;
            r_pos       <= 8'd0;
            r_cnt       <= 16'd0;
            r_coil      <= 4'b0000;
            r_energized <= 1'b0;
            r_pulse_q   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_pos       <= w_pos_nxt;
            r_cnt       <= w_cnt_nxt;
            r_coil      <= w_coil_nxt;
            r_energized <= w_energized_nxt;
            r_pulse_q   <= bus.pulse;
        end
    end

    assign bus.coil      = r_coil;
    assign bus.pos_o     = r_pos;
    assign bus.energized = r_energized;
endmodule

// File: tb/tb_stp_phase_drv.sv
// tb_stp_phase_drv: scoreboard bench for stp_phase_drv against a position-based reference model
module tb_stp_phase_drv;
    localparam int TO = 5;
`ifdef STP_HALF_STEP_EN
    localparam int N = 8;
    localparam logic [3:0] COIL4 = 4'b0010;
`else
    localparam int N = 4;
    localparam logic [3:0] COIL4 = 4'b1100;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] coil;
        logic [7:0] pos;
        logic       en;
    } exp_t;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    stp_phase_drv_if bus();
    stp_phase_drv #(.IDLE_TO(TO)) dut (.clk_i(clk), .rst_i(rst_i), .bus(bus));

    exp_t       q[$];
    exp_t       got_e;
    logic [3:0] tbl [8];
    int         ncyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         m_on, m_prev;
    int         m_pos, m_idle;

    always @(posedge clk) ncyc++;

    // Monitor: compares every registered output sample due by the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= ncyc) begin
            got_e = q.pop_front();
            checks++;
            if (bus.coil !== got_e.coil || bus.pos_o !== got_e.pos || bus.energized !== got_e.en) begin
                errors++;
                $display("FAIL scoreboard cyc %0d coil/pos/energized got %b/%h/%b exp %b/%h/%b",
                         ncyc, bus.coil, bus.pos_o, bus.energized, got_e.coil, got_e.pos, got_e.en);
            end
        end
    end

    task automatic chk(input string nm, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_prev = 0; m_pos = 0; m_idle = 0;
    endtask

    // Drive inputs for the next rising edge, predict its outcome, then wait for the following negedge.
    task automatic cyc(input logic en, input logic d, input logic p);
        exp_t e;
        bit   ener;
        bus.en = en; bus.dir = d; bus.pulse = p;
        if (!en) m_on = 0;
        else if (!m_on) begin m_on = 1; m_idle = 0; end
        else if (p && !m_prev) begin m_pos = (m_pos + (d ? 1 : 255)) % 256; m_idle = 0; end
        else if (m_idle < TO) m_idle++;
        m_prev = p;
        ener   = m_on && (TO == 0 || m_idle < TO);
        e.cyc  = ncyc + 1;
        e.coil = ener ? tbl[m_pos % N] : 4'b0000;
        e.pos  = m_pos[7:0];
        e.en   = ener;
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        logic p;
`ifdef STP_HALF_STEP_EN
        tbl = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
`else
        tbl = '{4'b1100, 4'b0110, 4'b0011, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
`endif
        rst_i = 1'b1; bus.en = 0; bus.dir = 0; bus.pulse = 0;
        model_reset();
        #12;
        chk("reset_outputs", {bus.coil, bus.pos_o, bus.energized}, 13'd0);
        @(negedge clk);
        rst_i = 1'b0;
        cyc(1, 0, 0); cyc(1, 0, 0);
        for (int i = 0; i < 4; i++) begin cyc(1, 1, 1); cyc(1, 1, 0); end
        #1 chk("four_cw_pos", {5'd0, bus.pos_o}, 13'h004);
        chk("four_cw_coil", {9'd0, bus.coil}, {9'd0, COIL4});
        cyc(1, 0, 1);
        #1 chk("ccw_pos", {5'd0, bus.pos_o}, 13'h003);
        cyc(1, 0, 0); cyc(1, 1, 1); cyc(1, 1, 0); cyc(1, 1, 1);
        for (int i = 0; i < TO - 1; i++) cyc(1, 1, 1);
        #1 chk("before_timeout", {12'd0, bus.energized}, 13'd1);
        cyc(1, 1, 1);
        #1 chk("at_timeout", {9'd0, bus.coil, bus.energized}, 13'd0);
        cyc(1, 1, 0); cyc(1, 1, 1); cyc(1, 1, 0);
        cyc(0, 1, 1); cyc(0, 1, 0); cyc(1, 1, 0); cyc(1, 1, 0);
        p = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 2) == 0) p = ~p;
            if (i % 100 > 80) p = 0;
            cyc($urandom_range(0, 19) != 0, 1'($urandom_range(0, 1)), p);
        end
        // Asynchronous reset while pulse is held high.
        cyc(1, 1, 0); cyc(1, 1, 1);
        #2 rst_i = 1'b1;
        #1 chk("async_reset", {bus.coil, bus.pos_o, bus.energized}, 13'd0);
        @(negedge clk);
        rst_i = 1'b0;
        model_reset();
        cyc(1, 1, 1); cyc(1, 1, 1);
        #1 chk("no_step_after_reset", {5'd0, bus.pos_o}, 13'd0);
        cyc(1, 1, 0); cyc(1, 1, 1); cyc(1, 1, 0);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
